maxpool_2x2_s2_collect: RTL and testbench

// - Downstream consumer of the 8-lane 2x2 window line buffer: 2x2/stride-2 max pooling on 8 channels in parallel.
// - Counts window positions across a square frame and keeps only stride-2 aligned windows (odd row AND odd col).
// - Emits one signed int8 max per lane per aligned window, with valid/last flags, toward the output-feature-map writer.

---
 rtl/maxpool_2x2_s2_collect_pkg.sv | 76 +++++++
 rtl/maxpool_2x2_s2_collect_max4.sv | 39 +++
 rtl/maxpool_2x2_s2_collect.sv | 153 +++++++++++++++
 tb/tb_maxpool_2x2_s2_collect.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_2x2_s2_collect_pkg.sv
// Shared constants, frame-size decoding and signed int8 helpers for the
// 2x2/stride-2 max-pool collector.
package maxpool_2x2_s2_collect_pkg;

  localparam int unsigned LANES = 8;

  // Default square frame sizes, one per sel code.
  localparam logic [7:0] LEN1_DEF = 8'd16;
  localparam logic [7:0] LEN2_DEF = 8'd14;
  localparam logic [7:0] LEN3_DEF = 8'd28;
  localparam logic [7:0] LEN4_DEF = 8'd56;
  localparam logic [7:0] LEN5_DEF = 8'd112;
  localparam logic [7:0] LEN6_DEF = 8'd224;

  // Frame-size select encoding shared with the upstream line buffer.
  typedef enum logic [2:0] {
    SEL_LEN1 = 3'd0,
    SEL_LEN2 = 3'd1,
    SEL_LEN3 = 3'd2,
    SEL_LEN4 = 3'd3,
    SEL_LEN5 = 3'd4,
    SEL_LEN6 = 3'd5
  } sel_e;

  // Frame tracking: idle between frames, busy while windows of a frame arrive.
  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_BUSY = 1'b1
  } frame_state_e;

  // Decode sel into a frame length; codes 6 and 7 fall back to the largest size.
  function automatic logic [7:0] sel_to_len(
    input logic [2:0] sel,
    input logic [7:0] l1,
    input logic [7:0] l2,
    input logic [7:0] l3,
    input logic [7:0] l4,
    input logic [7:0] l5,
    input logic [7:0] l6
  );
    logic [7:0] len;
    case (sel)
      SEL_LEN1: len = l1;
      SEL_LEN2: len = l2;
      SEL_LEN3: len = l3;
      SEL_LEN4: len = l4;
      SEL_LEN5: len = l5;
      default:  len = l6;
    endcase
    return len;
  endfunction

  // Extract one signed int8 byte from a packed 2x2 window.
  function automatic logic signed [7:0] win_byte(
    input logic [31:0] win,
    input logic [1:0]  idx
  );
    logic signed [7:0] b;
    case (idx)
      2'd0:    b = win[7:0];
      2'd1:    b = win[15:8];
      2'd2:    b = win[23:16];
      default: b = win[31:24];
    endcase
    return b;
  endfunction

  // Two's complement maximum of two int8 values.
  function automatic logic signed [7:0] smax8(
    input logic signed [7:0] a,
    input logic signed [7:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_2x2_s2_collect_max4.sv
// Two-stage signed int8 max tree over the four bytes of a 2x2 window.
// Output register only updates when a result arrives, so it holds otherwise.
module max4_s8_pipe
  import maxpool_2x2_s2_collect_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_win,
  output logic [7:0]  o_max
);

  logic              r_v1;
  logic signed [7:0] r_max01;
  logic signed [7:0] r_max23;
  logic signed [7:0] r_max;

  // Stage 1 pairs, stage 2 final max; stages load only behind a valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_max01 <= '0;
      r_max23 <= '0;
      r_max   <= '0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r_max01 <= smax8(win_byte(i_win, 2'd0), win_byte(i_win, 2'd1));
        r_max23 <= smax8(win_byte(i_win, 2'd2), win_byte(i_win, 2'd3));
      end
      if (r_v1) begin
        r_max <= smax8(r_max01, r_max23);
      end
    end
  end

  assign o_max = r_max;

endmodule

// File: rtl/maxpool_2x2_s2_collect.sv
// 8-lane 2x2/stride-2 max-pool collector: tracks window position over a
// square frame, keeps odd-row/odd-col windows and pools them per lane.
module maxpool_2x2_s2_collect
  import maxpool_2x2_s2_collect_pkg::*;
#(
  parameter logic [7:0] LEN1 = LEN1_DEF,
  parameter logic [7:0] LEN2 = LEN2_DEF,
  parameter logic [7:0] LEN3 = LEN3_DEF,
  parameter logic [7:0] LEN4 = LEN4_DEF,
  parameter logic [7:0] LEN5 = LEN5_DEF,
  parameter logic [7:0] LEN6 = LEN6_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  sel,
  input  logic        in_valid,
  input  logic [31:0] ifm_win2x2_0,
  input  logic [31:0] ifm_win2x2_1,
  input  logic [31:0] ifm_win2x2_2,
  input  logic [31:0] ifm_win2x2_3,
  input  logic [31:0] ifm_win2x2_4,
  input  logic [31:0] ifm_win2x2_5,
  input  logic [31:0] ifm_win2x2_6,
  input  logic [31:0] ifm_win2x2_7,
  output logic        pool_valid,
  output logic [7:0]  pool_out_0,
  output logic [7:0]  pool_out_1,
  output logic [7:0]  pool_out_2,
  output logic [7:0]  pool_out_3,
  output logic [7:0]  pool_out_4,
  output logic [7:0]  pool_out_5,
  output logic [7:0]  pool_out_6,
  output logic [7:0]  pool_out_7,
  output logic        pool_last,
  output logic        frame_busy
);

  logic [7:0]   r_col;
  logic [7:0]   r_row;
  logic [7:0]   r_len_q;
  frame_state_e r_state;
  frame_state_e w_state_nxt;

  logic         w_at_origin;
  logic         w_col_end;
  logic         w_row_end;
  logic         w_frame_end;
  logic         w_aligned;
  logic         w_pool_en;

  logic         r_v1;
  logic         r_v2;
  logic         r_l1;
  logic         r_l2;

  logic [31:0]  w_win [LANES];
  logic [7:0]   w_max [LANES];

  assign w_win[0] = ifm_win2x2_0;
  assign w_win[1] = ifm_win2x2_1;
  assign w_win[2] = ifm_win2x2_2;
  assign w_win[3] = ifm_win2x2_3;
  assign w_win[4] = ifm_win2x2_4;
  assign w_win[5] = ifm_win2x2_5;
  assign w_win[6] = ifm_win2x2_6;
  assign w_win[7] = ifm_win2x2_7;

  assign w_at_origin = (r_row == '0) && (r_col == '0);
  assign w_col_end   = (r_col == (r_len_q - 8'd1));
  assign w_row_end   = (r_row == (r_len_q - 8'd1));
  assign w_frame_end = w_col_end && w_row_end;
  assign w_aligned   = r_row[0] && r_col[0];
  assign w_pool_en   = in_valid && w_aligned;

  // Position counters and frame length latch; everything holds on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_len_q <= LEN1;
    end else if (in_valid) begin
      if (w_at_origin) begin
        r_len_q <= sel_to_len(sel, LEN1, LEN2, LEN3, LEN4, LEN5, LEN6);
      end
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 8'd1;
      end else begin
        r_col <= r_col + 8'd1;
      end
    end
  end

  // Valid/last delay line matching the two-stage max tree in every lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_l1 <= 1'b0;
      r_l2 <= 1'b0;
    end else begin
      r_v1 <= w_pool_en;
      r_l1 <= in_valid && w_frame_end;
      r_v2 <= r_v1;
      r_l2 <= r_l1;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame state transitions: enter on the first window, leave on the last.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FS_IDLE: if (in_valid && !w_frame_end) w_state_nxt = FS_BUSY;
      FS_BUSY: if (in_valid && w_frame_end)  w_state_nxt = FS_IDLE;
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  // Busy includes the accepting cycle itself, so a back-to-back (0,0)
  // window keeps it high across the frame boundary.
  assign frame_busy = rst_n && ((r_state == FS_BUSY) || in_valid);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    max4_s8_pipe u_max (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_pool_en),
      .i_win   (w_win[g]),
      .o_max   (w_max[g])
    );
  end

  assign pool_valid = r_v2;
  assign pool_last  = r_l2;
  assign pool_out_0 = w_max[0];
  assign pool_out_1 = w_max[1];
  assign pool_out_2 = w_max[2];
  assign pool_out_3 = w_max[3];
  assign pool_out_4 = w_max[4];
  assign pool_out_5 = w_max[5];
  assign pool_out_6 = w_max[6];
  assign pool_out_7 = w_max[7];

endmodule

// File: tb/tb_maxpool_2x2_s2_collect.sv
// Directed bench for the 8-lane 2x2/stride-2 max-pool collector.
module tb_maxpool_2x2_s2_collect;

  logic        clk;
  logic        rst_n;
  logic [2:0]  sel;
  logic        in_valid;
  logic [31:0] tb_win [8];
  logic        pool_valid;
  logic        pool_last;
  logic        frame_busy;
  logic [7:0]  po [8];

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic        last;
    logic [63:0] data;
  } rec_t;

  rec_t obs_q[$];
  rec_t exp_q[$];

  int   m_row = 0;
  int   m_col = 0;
  int   m_len = 16;
  logic ovr_en = 1'b0;
  int   ovr_n = -1;

  maxpool_2x2_s2_collect dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel          (sel),
    .in_valid     (in_valid),
    .ifm_win2x2_0 (tb_win[0]),
    .ifm_win2x2_1 (tb_win[1]),
    .ifm_win2x2_2 (tb_win[2]),
    .ifm_win2x2_3 (tb_win[3]),
    .ifm_win2x2_4 (tb_win[4]),
    .ifm_win2x2_5 (tb_win[5]),
    .ifm_win2x2_6 (tb_win[6]),
    .ifm_win2x2_7 (tb_win[7]),
    .pool_valid   (pool_valid),
    .pool_out_0   (po[0]),
    .pool_out_1   (po[1]),
    .pool_out_2   (po[2]),
    .pool_out_3   (po[3]),
    .pool_out_4   (po[4]),
    .pool_out_5   (po[5]),
    .pool_out_6   (po[6]),
    .pool_out_7   (po[7]),
    .pool_last    (pool_last),
    .frame_busy   (frame_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every pooled output at the falling edge.
  always @(negedge clk) begin
    if (pool_valid === 1'b1) begin
      obs_q.push_back({cyc, pool_last,
                       po[7], po[6], po[5], po[4], po[3], po[2], po[1], po[0]});
    end
  end

  function automatic int sel_len(input logic [2:0] s);
    case (s)
      3'd0:    return 16;
      3'd1:    return 14;
      3'd2:    return 28;
      3'd3:    return 56;
      3'd4:    return 112;
      default: return 224;
    endcase
  endfunction

  function automatic logic [31:0] mkwin(input int n, input int lane);
    logic [31:0] a;
    if (ovr_en && n == ovr_n) begin
      if (lane == 0) return 32'h807F00FF;
      if (lane == 1) return 32'h80808080;
      if (lane == 7) return 32'hFFFE8180;
    end
    a = 32'(n) * 32'h9E3779B1 + 32'(lane) * 32'h85EBCA77;
    return a ^ (a >> 13);
  endfunction

  function automatic logic [7:0] smax4(input logic [31:0] w);
    logic signed [7:0] m;
    logic signed [7:0] b;
    m = w[7:0];
    for (int k = 1; k < 4; k++) begin
      b = w[k*8 +: 8];
      if (b > m) m = b;
    end
    return m;
  endfunction

  // Drive one cycle of input and advance the reference position model.
  task automatic set_inputs(input logic v, input int n);
    rec_t r;
    in_valid = v;
    for (int l = 0; l < 8; l++) tb_win[l] = mkwin(n, l);
    if (v) begin
      if (m_row == 0 && m_col == 0) m_len = sel_len(sel);
      if ((m_row % 2) == 1 && (m_col % 2) == 1) begin
        r.cyc  = cyc + 2;
        r.last = (m_row == m_len - 1) && (m_col == m_len - 1);
        for (int l = 0; l < 8; l++) r.data[l*8 +: 8] = smax4(tb_win[l]);
        exp_q.push_back(r);
      end
      if (m_col == m_len - 1) begin
        m_col = 0;
        m_row = (m_row == m_len - 1) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_inputs(1'b0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    sel = 3'd0;
    for (int l = 0; l < 8; l++) tb_win[l] = '0;
    step();
    step();
    checks++;
    if (pool_valid !== 1'b0 || pool_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b last=%b want 0 0", pool_valid, pool_last);
    end
    checks++;
    if (frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", frame_busy);
    end
    for (int l = 0; l < 8; l++) begin
      checks++;
      if (po[l] !== 8'h00) begin
        errors++;
        $display("FAIL reset_out%0d: got %h want 00", l, po[l]);
      end
    end
    rst_n = 1'b1;
    m_row = 0; m_col = 0; m_len = 16;
    step();
  endtask

  task automatic test_frame14();
    int t15;
    int nlast;
    obs_q.delete(); exp_q.delete();
    sel = 3'd1;
    set_inputs(1'b0, 0);
    #3;
    checks++;
    if (frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL f14_busy_pre: got %b want 0", frame_busy);
    end
    step();
    set_inputs(1'b1, 0);
    #3;
    checks++;
    if (frame_busy !== 1'b1) begin
      errors++;
      $display("FAIL f14_busy_first: got %b want 1", frame_busy);
    end
    step();
    t15 = 0;
    for (int n = 1; n < 196; n++) begin
      if (n == 15) t15 = int'(cyc);
      set_inputs(1'b1, n);
      step();
    end
    set_inputs(1'b0, 0);
    #3;
    checks++;
    if (frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL f14_busy_after: got %b want 0", frame_busy);
    end
    idle(4);
    checks++;
    if (obs_q.size() != 49) begin
      errors++;
      $display("FAIL f14_count: got %0d want 49", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0].cyc != 32'(t15 + 2)) begin
        errors++;
        $display("FAIL f14_first_latency: got cycle %0d want %0d", obs_q[0].cyc, t15 + 2);
      end
    end
    nlast = 0;
    foreach (obs_q[i]) if (obs_q[i].last) nlast++;
    checks++;
    if (nlast != 1 || obs_q.size() < 49 || obs_q[obs_q.size()-1].last !== 1'b1) begin
      errors++;
      $display("FAIL f14_last: got %0d last pulses want 1 on output 49", nlast);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL f14_out[%0d]: got cyc=%0d last=%b data=%h want cyc=%0d last=%b data=%h",
                 i, obs_q[i].cyc, obs_q[i].last, obs_q[i].data,
                 exp_q[i].cyc, exp_q[i].last, exp_q[i].data);
      end
    end
  endtask

  task automatic test_signed_max();
    obs_q.delete(); exp_q.delete();
    sel = 3'd1;
    ovr_en = 1'b1;
    ovr_n = 15;
    for (int n = 0; n < 196; n++) begin
      set_inputs(1'b1, n);
      step();
    end
    idle(4);
    ovr_en = 1'b0;
    checks++;
    if (obs_q.size() == 0 || obs_q[0].data[7:0] !== 8'h7F) begin
      errors++;
      $display("FAIL signed_lane0: got %h want 7f", obs_q.size() > 0 ? obs_q[0].data[7:0] : 8'hxx);
    end
    checks++;
    if (obs_q.size() == 0 || obs_q[0].data[63:56] !== 8'hFF) begin
      errors++;
      $display("FAIL signed_lane7: got %h want ff", obs_q.size() > 0 ? obs_q[0].data[63:56] : 8'hxx);
    end
    checks++;
    if (obs_q.size() == 0 || obs_q[0].data[15:8] !== 8'h80) begin
      errors++;
      $display("FAIL signed_lane1_min: got %h want 80", obs_q.size() > 0 ? obs_q[0].data[15:8] : 8'hxx);
    end
  endtask

  task automatic test_bubbles16();
    int nlast;
    obs_q.delete(); exp_q.delete();
    sel = 3'd0;
    for (int n = 0; n < 256; n++) begin
      set_inputs(1'b1, n);
      step();
      set_inputs(1'b0, n + 500);
      step();
    end
    idle(4);
    checks++;
    if (obs_q.size() != 64) begin
      errors++;
      $display("FAIL bub_count: got %0d want 64", obs_q.size());
    end
    nlast = 0;
    foreach (obs_q[i]) if (obs_q[i].last) nlast++;
    checks++;
    if (nlast != 1) begin
      errors++;
      $display("FAIL bub_last: got %0d last pulses want 1", nlast);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bub_out[%0d]: got cyc=%0d last=%b data=%h want cyc=%0d last=%b data=%h",
                 i, obs_q[i].cyc, obs_q[i].last, obs_q[i].data,
                 exp_q[i].cyc, exp_q[i].last, exp_q[i].data);
      end
    end
  endtask

  task automatic test_sel_switch();
    int nlast;
    obs_q.delete(); exp_q.delete();
    sel = 3'd1;
    for (int n = 0; n < 196; n++) begin
      if (n == 50) sel = 3'd4;
      set_inputs(1'b1, n);
      step();
    end
    idle(3);
    checks++;
    if (obs_q.size() != 49 || obs_q.size() == 0 || obs_q[obs_q.size()-1].last !== 1'b1) begin
      errors++;
      $display("FAIL selsw_frame1: got %0d outputs want 49 ending with last", obs_q.size());
    end
    for (int n = 0; n < 12544; n++) begin
      set_inputs(1'b1, n + 7);
      step();
    end
    idle(4);
    checks++;
    if (obs_q.size() != 49 + 3136) begin
      errors++;
      $display("FAIL selsw_count: got %0d want %0d", obs_q.size(), 49 + 3136);
    end
    nlast = 0;
    foreach (obs_q[i]) if (obs_q[i].last) nlast++;
    checks++;
    if (nlast != 2) begin
      errors++;
      $display("FAIL selsw_last: got %0d last pulses want 2", nlast);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL selsw_out[%0d]: got cyc=%0d last=%b data=%h want cyc=%0d last=%b data=%h",
                 i, obs_q[i].cyc, obs_q[i].last, obs_q[i].data,
                 exp_q[i].cyc, exp_q[i].last, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int t15;
    int busy_hi;
    obs_q.delete(); exp_q.delete();
    sel = 3'd1;
    for (int n = 0; n < 16; n++) begin
      set_inputs(1'b1, n);
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (pool_valid !== 1'b0 || frame_busy !== 1'b0 || po[0] !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_during: got valid=%b busy=%b out0=%h want 0 0 00",
               pool_valid, frame_busy, po[0]);
    end
    rst_n = 1'b1;
    m_row = 0; m_col = 0; m_len = 16;
    exp_q.delete();
    busy_hi = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (frame_busy !== 1'b0) busy_hi++;
    end
    checks++;
    if (busy_hi != 0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got busy_cycles=%0d outputs=%0d want 0 0", busy_hi, obs_q.size());
    end
    t15 = 0;
    for (int n = 0; n < 196; n++) begin
      if (n == 15) t15 = int'(cyc);
      set_inputs(1'b1, n + 3);
      step();
    end
    idle(4);
    checks++;
    if (obs_q.size() != 49 || obs_q[0].cyc != 32'(t15 + 2)) begin
      errors++;
      $display("FAIL rstmid_restart: got %0d outputs first_cyc=%0d want 49 first_cyc=%0d",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0].cyc : 0, t15 + 2);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rstmid_out[%0d]: got cyc=%0d last=%b data=%h want cyc=%0d last=%b data=%h",
                 i, obs_q[i].cyc, obs_q[i].last, obs_q[i].data,
                 exp_q[i].cyc, exp_q[i].last, exp_q[i].data);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nlast;
    int busy_lo;
    obs_q.delete(); exp_q.delete();
    sel = 3'd1;
    busy_lo = 0;
    for (int n = 0; n < 392; n++) begin
      set_inputs(1'b1, n + 11);
      #3;
      if (frame_busy !== 1'b1) busy_lo++;
      step();
    end
    idle(4);
    checks++;
    if (busy_lo != 0) begin
      errors++;
      $display("FAIL b2b_busy: got %0d low cycles want 0", busy_lo);
    end
    checks++;
    if (obs_q.size() != 98) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 98", obs_q.size());
    end
    nlast = 0;
    foreach (obs_q[i]) if (obs_q[i].last) nlast++;
    checks++;
    if (nlast != 2 || obs_q.size() < 98 || obs_q[48].last !== 1'b1 || obs_q[97].last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last: got %0d last pulses want 2 at outputs 49 and 98", nlast);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_out[%0d]: got cyc=%0d last=%b data=%h want cyc=%0d last=%b data=%h",
                 i, obs_q[i].cyc, obs_q[i].last, obs_q[i].data,
                 exp_q[i].cyc, exp_q[i].last, exp_q[i].data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame14();
    test_signed_max();
    test_bubbles16();
    test_sel_switch();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
